// File: rtl/mc_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the 16-bit core.
// Instruction and data memories are variable-latency handshakes; control outputs are registered.
module mc_control_unit #(
    parameter int unsigned         DATA_WIDTH = 16,
    parameter int unsigned         PC_WIDTH   = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  instr_req,
    input  logic [15:0]           instr_in,
    input  logic                  instr_valid,
    input  logic                  zero_flag,
    input  logic                  pos_flag,
    input  logic                  mem_ready,
    output logic [PC_WIDTH-1:0]   PC,
    output logic [2:0]            rs_addr,
    output logic [2:0]            rt_addr,
    output logic [2:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] imm_data,
    output logic [3:0]            alu_sel,
    output logic                  imm_sel,
    output logic                  mem_sel,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  rf_write,
    output logic                  halted
);

    localparam int unsigned OFF_W = (PC_WIDTH > 10) ? PC_WIDTH : 10;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_MOVI  = 4'hB;
    localparam logic [3:0] OP_LOAD  = 4'hC;
    localparam logic [3:0] OP_STORE = 4'hD;
    localparam logic [3:0] OP_BR    = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    state_e                  state_q, state_d;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [15:0]             ir_q, ir_d;
    logic [2:0]              rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   imm_q, imm_d;
    logic [3:0]              alu_q, alu_d;
    logic                    imm_sel_q, imm_sel_d;
    logic                    mem_sel_q, mem_sel_d;
    logic                    instr_req_q, instr_req_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_write_q, mem_write_d;
    logic                    rf_write_q, rf_write_d;
    logic                    halted_q, halted_d;

    logic [3:0]              op_q, op_in;
    logic                    is_alu_q, is_alu_in;
    logic                    br_taken;
    logic [OFF_W-1:0]        br_off;

    assign op_q      = ir_q[15:12];
    assign op_in     = instr_in[15:12];
    assign is_alu_q  = (op_q != OP_NOP) && (op_q <= OP_MOVI);
    assign is_alu_in = (op_in != OP_NOP) && (op_in <= OP_MOVI);
    assign br_off    = OFF_W'($signed(ir_q[9:0]));

    // Branch condition evaluated against the externally registered flags during EXECUTE.
    always_comb begin
        br_taken = 1'b0;
        case (ir_q[11:10])
            2'b00:   br_taken = 1'b1;
            2'b01:   br_taken = zero_flag;
            2'b10:   br_taken = pos_flag;
            default: br_taken = ~zero_flag;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        alu_d     = alu_q;
        imm_sel_d = imm_sel_q;
        mem_sel_d = mem_sel_q;

        case (state_q)
            S_FETCH: begin
                // Decode fields are captured at accept so they are already valid during DECODE.
                if (instr_valid) begin
                    ir_d      = instr_in;
                    pc_d      = pc_q + PC_WIDTH'(1);
                    rd_d      = instr_in[11:9];
                    rs_d      = instr_in[8:6];
                    rt_d      = instr_in[5:3];
                    imm_d     = DATA_WIDTH'($signed(instr_in[8:0]));
                    alu_d     = is_alu_in ? op_in : 4'h0;
                    imm_sel_d = (op_in == OP_MOVI);
                    mem_sel_d = (op_in == OP_LOAD);
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_q == OP_NOP) begin
                    state_d = S_FETCH;
                end else if (op_q == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
                    state_d = S_MEM;
                end else if (op_q == OP_BR) begin
                    if (br_taken) begin
                        pc_d = pc_q + PC_WIDTH'(br_off);
                    end
                end else if (is_alu_q) begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        instr_req_d = (state_d == S_FETCH);
        mem_req_d   = (state_d == S_MEM);
        mem_write_d = (state_d == S_MEM) && (op_q == OP_STORE);
        rf_write_d  = (state_d == S_WB);
        halted_d    = (state_d == S_HALT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 16'h0000;
            rs_q        <= 3'd0;
            rt_q        <= 3'd0;
            rd_q        <= 3'd0;
            imm_q       <= '0;
            alu_q       <= 4'h0;
            imm_sel_q   <= 1'b0;
            mem_sel_q   <= 1'b0;
            instr_req_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            rf_write_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            imm_q       <= imm_d;
            alu_q       <= alu_d;
            imm_sel_q   <= imm_sel_d;
            mem_sel_q   <= mem_sel_d;
            instr_req_q <= instr_req_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            rf_write_q  <= rf_write_d;
            halted_q    <= halted_d;
        end
    end

    // The request flop resets high so fetch starts right after release; reset masks it meanwhile.
    assign instr_req = instr_req_q & reset;
    assign PC        = pc_q;
    assign rs_addr   = rs_q;
    assign rt_addr   = rt_q;
    assign rd_addr   = rd_q;
    assign imm_data  = imm_q;
    assign alu_sel   = alu_q;
    assign imm_sel   = imm_sel_q;
    assign mem_sel   = mem_sel_q;
    assign mem_req   = mem_req_q;
    assign mem_write = mem_write_q;
    assign rf_write  = rf_write_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: a program table run through a fetch/memory responder,
// plus hand-written halt and reset-during-MEM sequences.
module tb_mc_control_unit;

    localparam int unsigned DW = 16;
    localparam int unsigned PW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          instr_req;
    logic [15:0]   instr_in;
    logic          instr_valid;
    logic          zero_flag;
    logic          pos_flag;
    logic          mem_ready;
    logic [PW-1:0] PC;
    logic [2:0]    rs_addr, rt_addr, rd_addr;
    logic [DW-1:0] imm_data;
    logic [3:0]    alu_sel;
    logic          imm_sel, mem_sel, mem_req, mem_write, rf_write, halted;

    mc_control_unit #(
        .DATA_WIDTH(DW),
        .PC_WIDTH  (PW),
        .RESET_PC  (8'd0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .instr_req  (instr_req),
        .instr_in   (instr_in),
        .instr_valid(instr_valid),
        .zero_flag  (zero_flag),
        .pos_flag   (pos_flag),
        .mem_ready  (mem_ready),
        .PC         (PC),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rd_addr    (rd_addr),
        .imm_data   (imm_data),
        .alu_sel    (alu_sel),
        .imm_sel    (imm_sel),
        .mem_sel    (mem_sel),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .rf_write   (rf_write),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
        int          vwait;
        int          mwait;
        logic        zf;
        logic        pf;
        logic [3:0]  alu;
        logic        chk_alu;
        logic [15:0] imm;
        logic        chk_imm;
        logic        isel;
        logic        msel;
        logic        chk_msel;
        int          lat;
        logic        halt;
        int          rf_n;
        int          rf_k;
        int          mr_n;
        int          mw_n;
        logic [7:0]  next_pc;
    } vec_t;

    vec_t vecs[16];
    vec_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] pc, input logic [15:0] instr,
                                input int vw, input int mw, input logic zf, input logic pf,
                                input logic [3:0] alu, input logic chk_alu,
                                input logic [15:0] imm, input logic chk_imm,
                                input logic isel, input logic msel, input logic chk_msel,
                                input int lat, input logic halt, input int rf_n, input int rf_k,
                                input int mr_n, input int mw_n, input logic [7:0] next_pc);
        vec_t v;
        v.pc = pc; v.instr = instr; v.vwait = vw; v.mwait = mw; v.zf = zf; v.pf = pf;
        v.alu = alu; v.chk_alu = chk_alu; v.imm = imm; v.chk_imm = chk_imm;
        v.isel = isel; v.msel = msel; v.chk_msel = chk_msel;
        v.lat = lat; v.halt = halt; v.rf_n = rf_n; v.rf_k = rf_k;
        v.mr_n = mr_n; v.mw_n = mw_n; v.next_pc = next_pc;
        return v;
    endfunction

    // Fetch one instruction, then act as data memory until the next fetch request or halt.
    task automatic run_one(input vec_t v);
        vec_t        e;
        logic [15:0] ins;
        int          k, n_rf, rf_k, n_mr, n_mw, n_req;
        zero_flag = v.zf;
        pos_flag  = v.pf;
        check("fetch_pc", 32'(PC), 32'(v.pc));
        n_req = 0;
        for (int i = 0; i < v.vwait; i++) begin
            if (instr_req) n_req++;
            @(posedge clock); #1;
        end
        if (instr_req) n_req++;
        instr_valid = 1'b1;
        instr_in    = v.instr;
        sb_q.push_back(v);
        @(posedge clock); #1;
        instr_valid = 1'b0;
        instr_in    = 16'h0000;
        check("fetch_req_cycles", 32'(n_req), 32'(v.vwait + 1));
        k = 1; n_rf = 0; rf_k = 0; n_mr = 0; n_mw = 0;
        while (!(instr_req || halted) && k < 40) begin
            if (k == 1) begin
                e   = sb_q[0];
                ins = e.instr;
                check("decode_pc", 32'(PC), 32'(8'(e.pc + 8'd1)));
                check("decode_rd", 32'(rd_addr), 32'(ins[11:9]));
                check("decode_rs", 32'(rs_addr), 32'(ins[8:6]));
                check("decode_rt", 32'(rt_addr), 32'(ins[5:3]));
                check("decode_imm_sel", 32'(imm_sel), 32'(e.isel));
                if (e.chk_alu)  check("decode_alu_sel", 32'(alu_sel), 32'(e.alu));
                if (e.chk_imm)  check("decode_imm_data", 32'(imm_data), 32'(e.imm));
                if (e.chk_msel) check("decode_mem_sel", 32'(mem_sel), 32'(e.msel));
            end
            if (rf_write) begin
                n_rf++;
                if (rf_k == 0) rf_k = k;
            end
            if (mem_write) n_mw++;
            if (mem_req) begin
                n_mr++;
                mem_ready = (n_mr > v.mwait);
            end else begin
                mem_ready = 1'b0;
            end
            @(posedge clock); #1;
            k++;
        end
        mem_ready = 1'b0;
        e = sb_q.pop_front();
        check("halted", 32'(halted), 32'(e.halt));
        check("latency", 32'(k), 32'(e.lat));
        check("rf_write_count", 32'(n_rf), 32'(e.rf_n));
        check("rf_write_cycle", 32'(rf_k), 32'(e.rf_k));
        check("mem_req_cycles", 32'(n_mr), 32'(e.mr_n));
        check("mem_write_cycles", 32'(n_mw), 32'(e.mw_n));
        check("req_overlap", 32'(instr_req & mem_req), 32'(0));
        if (!e.halt) check("next_pc", 32'(PC), 32'(e.next_pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //            pc      instr    vw mw zf    pf    alu  ca    imm       ci    isel  msel  cm    lat halt rf rk mr mw next
        vecs[0]  = mk(8'd0,   16'hB605, 0, 0, 1'b0, 1'b0, 4'hB, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b0, 1, 3, 0, 0, 8'd1);
        vecs[1]  = mk(8'd1,   16'hB3FF, 0, 0, 1'b0, 1'b0, 4'hB, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b0, 1, 3, 0, 0, 8'd2);
        vecs[2]  = mk(8'd2,   16'hC500, 5, 3, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0, 1, 7, 4, 0, 8'd3);
        vecs[3]  = mk(8'd3,   16'hE7FE, 0, 0, 1'b1, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 0, 0, 0, 0, 8'd2);
        vecs[4]  = mk(8'd2,   16'h1A98, 0, 0, 1'b0, 1'b0, 4'h1, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1, 3, 0, 0, 8'd3);
        vecs[5]  = mk(8'd3,   16'hE7FE, 0, 0, 1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 0, 0, 0, 0, 8'd4);
        vecs[6]  = mk(8'd4,   16'h0000, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0, 0, 0, 0, 0, 8'd5);
        vecs[7]  = mk(8'd5,   16'hAE50, 2, 0, 1'b0, 1'b0, 4'hA, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0, 1, 3, 0, 0, 8'd6);
        vecs[8]  = mk(8'd6,   16'hE803, 0, 0, 1'b1, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 0, 0, 0, 0, 8'd7);
        vecs[9]  = mk(8'd7,   16'hD0D0, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 0, 0, 1, 1, 8'd8);
        vecs[10] = mk(8'd8,   16'hEC02, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 0, 0, 0, 0, 8'd11);
        vecs[11] = mk(8'd11,  16'hC500, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 5, 1'b0, 1, 4, 1, 0, 8'd12);
        vecs[12] = mk(8'd12,  16'hE8F1, 0, 0, 1'b0, 1'b1, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 0, 0, 0, 0, 8'd254);
        vecs[13] = mk(8'd254, 16'hE005, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 0, 0, 0, 0, 8'd4);
        vecs[14] = mk(8'd4,   16'hD0D0, 0, 2, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 6, 1'b0, 0, 0, 3, 3, 8'd5);
        vecs[15] = mk(8'd5,   16'hF000, 0, 0, 1'b0, 1'b0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 0, 0, 0, 0, 8'd0);

        reset       = 1'b0;
        instr_valid = 1'b0;
        instr_in    = 16'h0000;
        zero_flag   = 1'b0;
        pos_flag    = 1'b0;
        mem_ready   = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_ctrl", 32'({instr_req, mem_req, mem_write, rf_write, halted, imm_sel, mem_sel}), 32'(0));
        check("rst_pc", 32'(PC), 32'(0));
        check("rst_fields", 32'({rd_addr, rs_addr, rt_addr, alu_sel}), 32'(0));
        check("rst_imm", 32'(imm_data), 32'(0));
        reset = 1'b1;
        #1;
        check("req_after_release", 32'(instr_req), 32'(1));

        for (int i = 0; i < 16; i++) begin
            run_one(vecs[i]);
        end

        // Halted core ignores fetch and memory responses.
        instr_valid = 1'b1;
        instr_in    = 16'hB605;
        mem_ready   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            check("halt_hold", 32'({halted, instr_req, mem_req, rf_write}), 32'(4'b1000));
        end
        instr_valid = 1'b0;
        mem_ready   = 1'b0;

        // Reset from HALT, then assert reset while a STORE sits in MEM.
        reset = 1'b0;
        #1;
        check("rst_from_halt", 32'({halted, instr_req}), 32'(0));
        check("rst_from_halt_pc", 32'(PC), 32'(0));
        @(posedge clock); #1;
        reset       = 1'b1;
        #1;
        instr_valid = 1'b1;
        instr_in    = 16'hD0D0;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("store_in_mem", 32'({mem_req, mem_write}), 32'(2'b11));
        @(posedge clock); #1;
        check("store_wait_mem", 32'({mem_req, mem_write}), 32'(2'b11));
        check("store_pc", 32'(PC), 32'(1));
        #2;
        reset = 1'b0;
        #1;
        check("async_abort", 32'({mem_req, mem_write, instr_req}), 32'(0));
        check("async_abort_pc", 32'(PC), 32'(0));
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("abort_quiet", 32'({mem_req, mem_write, rf_write}), 32'(0));
        end
        mem_ready = 1'b0;
        reset     = 1'b1;
        #1;
        check("restart_req", 32'(instr_req), 32'(1));
        run_one(mk(8'd0, 16'hB605, 0, 0, 1'b0, 1'b0, 4'hB, 1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b1,
                   4, 1'b0, 1, 3, 0, 0, 8'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
